// File: rtl/test_seq_pkg.sv
// Shared types and defaults for the self-test sequencer.
// Holds the sequencer state encoding and the default channel/timeout sizing.
package test_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      NEXT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int DEF_NUM_CH  = 10;
   localparam int DEF_TIMEOUT = 20000;

endpackage

// File: rtl/test_sequencer_timeout_counter.sv
// Saturating per-channel wait counter for test_sequencer.
// expired is high while the count sits at TIMEOUT-1; the count never wraps.
module timeout_counter #(
   parameter int TIMEOUT = test_seq_pkg::DEF_TIMEOUT,
   parameter int CNT_W   = $clog2(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   assign expired = (count == TERM);

   // Clear has priority so a fresh channel always starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/test_sequencer.sv
// Self-test controller: runs NUM_CH unit-test channels in turn, sticky pass/timeout per channel.
// Build option TEST_SEQ_FAILSTOP_EN: stop the run at the first failing or timed-out channel.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = $clog2(TIMEOUT),
   parameter int IDX_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic [NUM_CH-1:0] ch_start,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic [NUM_CH-1:0] ch_pass,
   output logic [IDX_W-1:0]  cur_ch,
   output logic              busy,
   output logic              complete,
   output logic [NUM_CH-1:0] result,
   output logic [NUM_CH-1:0] timeout_flags,
   output logic              all_passed,
   output state_t            fsm_state
);

   localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

   state_t            state;
   state_t            state_d;
   logic [IDX_W-1:0]  cur_ch_d;
   logic [NUM_CH-1:0] result_d;
   logic [NUM_CH-1:0] timeout_d;
   logic              expired;

   timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == START),
      .enable  (state == WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cur_ch        <= '0;
         result        <= '0;
         timeout_flags <= '0;
      end else begin
         state         <= state_d;
         cur_ch        <= cur_ch_d;
         result        <= result_d;
         timeout_flags <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state;
      cur_ch_d  = cur_ch;
      result_d  = result;
      timeout_d = timeout_flags;
      case (state)
         IDLE, DONE: begin
            if (go) begin
               state_d   = START;
               cur_ch_d  = '0;
               result_d  = '0;
               timeout_d = '0;
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            // A done seen on the terminal count still counts as a completed channel.
            if (ch_done[cur_ch]) begin
               result_d[cur_ch] = ch_pass[cur_ch];
               state_d          = NEXT;
            end else if (expired) begin
               result_d[cur_ch]  = 1'b0;
               timeout_d[cur_ch] = 1'b1;
               state_d           = NEXT;
            end
         end
         NEXT: begin
`ifdef TEST_SEQ_FAILSTOP_EN
            if ((cur_ch == LAST_CH) || !result[cur_ch]) begin
               state_d = DONE;
            end else begin
               cur_ch_d = cur_ch + IDX_W'(1);
               state_d  = START;
            end
`else
            if (cur_ch == LAST_CH) begin
               state_d = DONE;
            end else begin
               cur_ch_d = cur_ch + IDX_W'(1);
               state_d  = START;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Start pulse is a decode of the state register, so reset drops it immediately.
   always_comb begin
      ch_start = '0;
      if (state == START) begin
         ch_start[cur_ch] = 1'b1;
      end
   end

   assign busy       = (state == START) || (state == WAIT) || (state == NEXT);
   assign complete   = (state == DONE);
   assign all_passed = complete && (&result);
   assign fsm_state  = state;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer with NUM_CH=4, TIMEOUT=8 and a behavioural channel responder.
// Expected result/timeout vectors are queued at go and popped when complete rises.
module tb_test_sequencer;
   import test_seq_pkg::*;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 8;
   localparam int IDX_W   = $clog2(NUM_CH);
   localparam int W       = 2 * NUM_CH;
   localparam int NEVER   = 1000;

   logic              clk = 1'b0;
   logic              reset;
   logic              go;
   logic [NUM_CH-1:0] ch_start;
   logic [NUM_CH-1:0] ch_done;
   logic [NUM_CH-1:0] ch_pass;
   logic [IDX_W-1:0]  cur_ch;
   logic              busy;
   logic              complete;
   logic [NUM_CH-1:0] result;
   logic [NUM_CH-1:0] timeout_flags;
   logic              all_passed;
   state_t            fsm_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   int dly[NUM_CH];
   logic [NUM_CH-1:0] pass_v;
   logic [NUM_CH-1:0] act;
   int wc[NUM_CH];
   int wcnt[NUM_CH];
   int pulses[NUM_CH];
   int end_cyc;

   test_sequencer #(
      .NUM_CH  (NUM_CH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .go            (go),
      .ch_start      (ch_start),
      .ch_done       (ch_done),
      .ch_pass       (ch_pass),
      .cur_ch        (cur_ch),
      .busy          (busy),
      .complete      (complete),
      .result        (result),
      .timeout_flags (timeout_flags),
      .all_passed    (all_passed),
      .fsm_state     (fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Channel model: after its start pulse, done rises dly[i] cycles into WAIT.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         act <= '0;
         for (int i = 0; i < NUM_CH; i++) wc[i] <= 0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_start[i]) begin
               act[i] <= 1'b1;
               wc[i]  <= 0;
            end else if (act[i]) begin
               if (ch_done[i]) act[i] <= 1'b0;
               else wc[i] <= wc[i] + 1;
            end
         end
      end
   end

   always_comb begin
      ch_done = '0;
      for (int i = 0; i < NUM_CH; i++) ch_done[i] = act[i] && (wc[i] == dly[i]);
   end

   assign ch_pass = pass_v;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NUM_CH-1:0] model_result(input logic [NUM_CH-1:0] p,
                                                      input logic [NUM_CH-1:0] to);
      logic [NUM_CH-1:0] r;
      logic stop;
      r    = '0;
      stop = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!stop) begin
            r[i] = to[i] ? 1'b0 : p[i];
`ifdef TEST_SEQ_FAILSTOP_EN
            if (!r[i]) stop = 1'b1;
`endif
         end
      end
      return r;
   endfunction

   // Drive go, follow the run to DONE, then pop and compare the expected vectors.
   task automatic run_once(input logic [NUM_CH-1:0] exp_res, input logic [NUM_CH-1:0] exp_tf,
                           input int busy_go_cyc);
      logic [W-1:0] exp;
      logic [IDX_W-1:0] saved_ch;
      bit injected;
      int cyc;
      exp_q.push_back({exp_tf, exp_res});
      for (int i = 0; i < NUM_CH; i++) begin
         wcnt[i]   = 0;
         pulses[i] = 0;
      end
      injected = 1'b0;
      saved_ch = '0;
      go = 1'b1;
      @(posedge clk); #1;
      go  = 1'b0;
      cyc = 1;
      check_eq("start_state", fsm_state, START);
      check_eq("start_vectors_clear", {result, timeout_flags, 2'(cur_ch)}, '0);
      while (!complete && cyc < 400) begin
         if (fsm_state == WAIT) wcnt[cur_ch]++;
         for (int i = 0; i < NUM_CH; i++) if (ch_start[i]) pulses[i]++;
         if (go) begin
            go = 1'b0;
            check_eq("busy_go_cur_ch", cur_ch, saved_ch);
         end
         if (!injected && busy_go_cyc > 0 && cyc >= busy_go_cyc && fsm_state == WAIT) begin
            injected = 1'b1;
            saved_ch = cur_ch;
            go       = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      go      = 1'b0;
      end_cyc = cyc;
      check_eq("run_complete", complete, 1'b1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check_eq("result", result, exp[NUM_CH-1:0]);
         check_eq("timeout_flags", timeout_flags, exp[W-1:NUM_CH]);
         check_eq("all_passed", all_passed, &exp[NUM_CH-1:0]);
      end
   endtask

   initial begin
      logic [NUM_CH-1:0] seen;
      logic [NUM_CH-1:0] rp;
      int guard;
      reset  = 1'b1;
      go     = 1'b0;
      pass_v = '1;
      for (int i = 0; i < NUM_CH; i++) dly[i] = 2;

      // reset held, then released
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_state", fsm_state, IDLE);
      check_eq("rst_outputs", {ch_start, result, timeout_flags, 2'(cur_ch), busy, complete, all_passed}, '0);
      #2 reset = 1'b0;
      seen = '0;
      repeat (5) begin
         @(posedge clk); #1;
         seen |= ch_start;
      end
      check_eq("idle_no_start", seen, '0);
      check_eq("idle_state", fsm_state, IDLE);

      // all channels pass two cycles into WAIT; go pulsed while busy
      run_once(4'b1111, 4'b0000, 3);
      check_eq("complete_cycle", end_cyc, 21);
      check_eq("wait_cycles_ch0", wcnt[0], 3);

      // channel 2 times out; restart from DONE
      dly[2] = NEVER;
      run_once(model_result(4'b1111, 4'b0100), 4'b0100, 0);
      check_eq("timeout_wait_cycles", wcnt[2], TIMEOUT);

      // done on terminal count wins over timeout
      dly[2] = 2;
      dly[0] = TIMEOUT - 1;
      run_once(4'b1111, 4'b0000, 0);
      check_eq("edge_wait_cycles", wcnt[0], TIMEOUT);

      // channel 1 fails
      dly[0] = 2;
      pass_v = 4'b1101;
      run_once(model_result(4'b1101, 4'b0000), 4'b0000, 0);
`ifdef TEST_SEQ_FAILSTOP_EN
      check_eq("failstop_pulses", {pulses[3][7:0], pulses[2][7:0]}, 16'h0000);
`else
      check_eq("nostop_pulses", {pulses[3][7:0], pulses[2][7:0]}, 16'h0101);
`endif

      // reset during channel 1 WAIT
      pass_v = '1;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      guard = 0;
      while (!(fsm_state == WAIT && cur_ch == 1) && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check_eq("reach_ch1_wait", guard < 100, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst_state", fsm_state, IDLE);
      check_eq("async_rst_outputs", {ch_start, result, timeout_flags, 2'(cur_ch), busy, complete, all_passed}, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      run_once(4'b1111, 4'b0000, 0);

      // randomised delays and verdicts
      repeat (3) begin
         for (int i = 0; i < NUM_CH; i++) dly[i] = $urandom_range(0, TIMEOUT - 1);
         rp     = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
         pass_v = rp;
         run_once(model_result(rp, '0), '0, 0);
      end

      check_eq("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Synthesizable self-test controller, the parametrised successor to the all-tests bench harness. It runs NUM_CH unit-test channels one at a time. For each channel it pulses a start, waits for done or a timeout, and records per-channel pass and timeout results into sticky vectors. It sits above the component testbenches (adder, datamemory, regfile, shifter, …) and replaces the fixed wait-then-AND-reduce with cycle-accurate, per-channel reporting.

## Interface
- NUM_CH, 10: number of test channels (≥2).
- TIMEOUT, 20000: maximum WAIT cycles per channel (≥2).
- CNT_W, $clog2(TIMEOUT): timeout counter width.
- IDX_W, $clog2(NUM_CH): channel index width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- go  in  1  start or restart a run; sampled only in IDLE or DONE.
- ch_start  out  NUM_CH  one-hot, one-cycle start pulse to the current channel.
- ch_done  in  NUM_CH  channel finished; sampled only for the current channel, only in WAIT.
- ch_pass  in  NUM_CH  channel verdict, valid when the matching ch_done is high.
- cur_ch  out  IDX_W  index of the channel under test.
- busy  out  1  high in START, WAIT, NEXT.
- complete  out  1  high in DONE.
- result  out  NUM_CH  sticky pass bit per channel.
- timeout_flags  out  NUM_CH  sticky timeout bit per channel.
- all_passed  out  1  complete && &result.

## Operation
- States: IDLE, START, WAIT, NEXT, DONE.
- Reset values: state=IDLE, cur_ch=0, counter=0, ch_start=0, result=0, timeout_flags=0, busy=0, complete=0, all_passed=0.
- IDLE, go=1 → START. Also clears result, timeout_flags, cur_ch.
- START: ch_start[cur_ch]=1 for exactly this cycle; counter←0; → WAIT.
- WAIT: counter increments each cycle.
  - ch_done[cur_ch]=1 → result[cur_ch]←ch_pass[cur_ch]; → NEXT.
  - Otherwise, counter==TIMEOUT-1 → result[cur_ch]←0, timeout_flags[cur_ch]←1; → NEXT.
  - Done and timeout in the same cycle: done wins, no timeout flag.
- NEXT: cur_ch==NUM_CH-1 → DONE; else cur_ch←cur_ch+1, → START.
- DONE: outputs hold. go=1 → clear vectors, cur_ch←0, → START.
- go while busy: ignored.
- ch_done/ch_pass of non-current channels, or outside WAIT: ignored.
- Counter saturates; it never wraps inside WAIT.
- Reset mid-run: immediate return to reset values, any in-flight ch_start dropped, no partial results retained.

## Timing
- go sampled in cycle 0 → START in cycle 1.
- Per channel: 1 START + (k+1) WAIT + 1 NEXT, where k = cycles from START to done being high (k ≤ TIMEOUT-1).
- Timed-out channel: exactly TIMEOUT WAIT cycles.
- result/timeout_flags update on the edge that leaves WAIT and are visible in NEXT.
- complete/all_passed are registered-state decodes, high from the first DONE cycle.

## Configuration
- TEST_SEQ_FAILSTOP_EN defined: in NEXT, if result[cur_ch]==0 (fail or timeout) → DONE immediately; later channels are left unrun (result=0, timeout_flags=0).
- Undefined: every channel runs regardless of earlier failures.

## Structure
- Package test_seq_pkg: state enum (IDLE, START, WAIT, NEXT, DONE) and default NUM_CH/TIMEOUT constants.
- Sub-module timeout_counter: CNT_W-bit counter with clear, enable, and saturating terminal-count output expired (count==TIMEOUT-1).
- FSM and result registers stay in test_sequencer.

## Test plan
All scenarios use NUM_CH=4, TIMEOUT=8.
- Reset held, then released → all outputs 0, state IDLE; ch_start stays 0 without go.
- go, each channel asserts done with pass=1 two cycles after its start pulse → complete rises in cycle 21; result=4'b1111, timeout_flags=0, all_passed=1.
- Channel 2 never asserts done, others pass → channel 2 spends exactly 8 WAIT cycles; result=4'b1011, timeout_flags=4'b0100, all_passed=0.
- Channel 0 asserts done with pass=1 on WAIT counter value 7 → result[0]=1, timeout_flags[0]=0.
- Channel 1 reports pass=0 → with TEST_SEQ_FAILSTOP_EN: DONE after channel 1, result=4'b0001, channels 2–3 never pulsed; without it: result=4'b1101.
- reset pulsed during channel 1 WAIT, then go → all outputs clear asynchronously; the new run starts at cur_ch=0 with fresh vectors.
- go asserted while busy → no effect on cur_ch or counter.
